sdram_req_frontend: RTL and testbench
=====================================

// Module: sdram_req_frontend
// PURPOSE
//  Request front-end that sits directly upstream of the SDRAM controller. It turns user burst
//  requests into sdram_pkg::sdram_cmd_t commands and buffers write data in a FIFO. Write commands
//  are released only once a full burst is buffered, so the controller's WRITE_BURST never sees a
//  gap. It also bounds the number of read bursts in flight, tracked via a completion pulse from
//  the response path.
// PARAMETERS
//  ADDR_WIDTH          24   word address width (bank[23:22], row[21:9], col[8:0])
//  DATA_WIDTH          16   data word width
//  BURST_LEN           8    words per burst; power of 2; matches the controller's MRS burst length
//  FIFO_DEPTH          16   write-data FIFO depth in words; power of 2, >= BURST_LEN
//  MAX_RD_OUTSTANDING  2    maximum read bursts issued but not yet completed (>= 1)
// PORTS
//  clk              in   1                  system clock
//  rst              in   1                  synchronous, active-high reset
//  req_valid        in   1                  user request valid
//  req_ready        out  1                  user request accepted when req_valid & req_ready
//  req_write        in   1                  1 = write burst, 0 = read burst
//  req_addr         in   ADDR_WIDTH         burst start word address
//  req_auto_pre     in   1                  request auto-precharge after the burst
//  usr_wdata_valid  in   1                  user write word valid
//  usr_wdata_ready  out  1                  FIFO not full
//  usr_wdata        in   DATA_WIDTH         user write word
//  usr_wdqm         in   2                  byte mask stored with the word
//  cmd_valid        out  1                  command to controller (cmd_fifo_valid)
//  cmd_ready        in   1                  controller cmd_fifo_ready
//  cmd_data         out  sdram_cmd_t        {addr, rw, auto_precharge_en}
//  wdata_valid      out  1                  write word to controller
//  wdata_ready      in   1                  controller wdata_ready
//  wdata            out  DATA_WIDTH         FIFO head word
//  wdata_dqm        out  2                  FIFO head mask
//  resp_done        in   1                  one-cycle pulse = controller resp_valid & resp_ready & resp_last
//  rd_outstanding   out  $clog2(MAX_RD_OUTSTANDING+1)  read bursts in flight
// BEHAVIOUR
//  - Reset: state IDLE; FIFO pointers and count = 0; rd_outstanding = 0; cmd_valid = 0;
//    wdata_valid = 0; cmd_data = 0. req_ready and usr_wdata_ready may be high in the first
//    post-reset cycle (IDLE / empty FIFO). Reset mid-operation discards all FIFO contents and any
//    pending command.
//  - FIFO: push on usr_wdata_valid & usr_wdata_ready, independent of FSM state.
//    usr_wdata_ready = (count < FIFO_DEPTH). Pop on wdata_valid & wdata_ready.
//    A simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
//    Data and dqm are stored together. wdata and wdata_dqm always show the FIFO head.
//  - Address: the low $clog2(BURST_LEN) bits of req_addr are forced to 0 in cmd_data.addr.
//    cmd_data is latched on request acceptance and held stable while cmd_valid = 1.
//  - FSM:
//    IDLE:     req_ready = req_write | (rd_outstanding < MAX_RD_OUTSTANDING).
//              On accept: latch command; go to WAIT_WD if write, else ISSUE.
//    WAIT_WD:  go to ISSUE when count >= BURST_LEN (evaluated on the registered count).
//    ISSUE:    cmd_valid = 1 until cmd_ready.
//              On handshake: write -> STREAM with beat_cnt = BURST_LEN;
//              read -> IDLE, rd_outstanding += 1.
//    STREAM:   wdata_valid = (count != 0), which stays high for the whole burst.
//              Each pop decrements beat_cnt. On the pop with beat_cnt == 1 -> IDLE.
//  - wdata_valid = 0 outside STREAM. This prevents the controller from grabbing words belonging
//    to a later burst.
//  - rd_outstanding: +1 on read cmd handshake, -1 on resp_done; simultaneous events leave it
//    unchanged. resp_done while rd_outstanding == 0 is ignored (no underflow).
//  - Latency: a read request reaches cmd_valid 1 cycle after acceptance. A write reaches cmd_valid
//    1 cycle after the BURST_LEN-th word is buffered (or 1 cycle after acceptance if already
//    buffered).
//  - Only one request is in the FSM at a time. Ordering is strictly the user request order.
// TESTING
//  1. Write req addr 0x000100; push words 0x1000..0x1007, one per cycle -> cmd_valid rises the
//     cycle after the 8th push; cmd_data = {0x000100, WRITE}; 8 gapless wdata beats in order
//     with wdata_ready = 1.
//  2. Three back-to-back reads, no resp_done -> first two issue; req_ready low with
//     rd_outstanding = 2. One resp_done pulse -> third read accepted next cycle.
//  3. Push 16 words with no request -> usr_wdata_ready low after the 16th; a write req then
//     issues cmd 1 cycle after acceptance; FIFO count drops to 8 after STREAM.
//  4. Read req addr 0x000105, req_auto_pre = 1 -> cmd_data.addr = 0x000100, auto_precharge_en = 1.
//  5. wdata_ready toggling every other cycle during STREAM -> 8 words delivered in order;
//     returns to IDLE after the 8th pop; no extra beat.
//  6. Assert rst after 3 pops in STREAM -> next cycle: cmd_valid = wdata_valid = 0,
//     count = 0, rd_outstanding = 0, req_ready = 1.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM controller and its request front-end.
package sdram_pkg;

  // Command record handed to the controller; rw = 1 selects a write burst.
  typedef struct packed {
    logic [23:0] addr;
    logic        rw;
    logic        auto_precharge_en;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_req_frontend.sv
// Request front-end for the SDRAM controller: converts user bursts into commands,
// buffers write data so a write burst is never starved, and bounds reads in flight.
module sdram_req_frontend
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH         = 24,
  parameter int DATA_WIDTH         = 16,
  parameter int BURST_LEN          = 8,
  parameter int FIFO_DEPTH         = 16,
  parameter int MAX_RD_OUTSTANDING = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic                                        req_write,
  input  logic [ADDR_WIDTH-1:0]                       req_addr,
  input  logic                                        req_auto_pre,
  input  logic                                        usr_wdata_valid,
  output logic                                        usr_wdata_ready,
  input  logic [DATA_WIDTH-1:0]                       usr_wdata,
  input  logic [1:0]                                  usr_wdqm,
  output logic                                        cmd_valid,
  input  logic                                        cmd_ready,
  output sdram_cmd_t                                  cmd_data,
  output logic                                        wdata_valid,
  input  logic                                        wdata_ready,
  output logic [DATA_WIDTH-1:0]                       wdata,
  output logic [1:0]                                  wdata_dqm,
  input  logic                                        resp_done,
  output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0]     rd_outstanding
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int RD_W   = $clog2(MAX_RD_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT_WD, ISSUE, STREAM} state_t;

  state_t              state_q, state_d;
  sdram_cmd_t          cmd_q, cmd_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [DATA_WIDTH+1:0] mem_q [FIFO_DEPTH];

  logic push, pop, burst_buffered, rd_inc, rd_dec;

  // ---------------- write-data FIFO (data and mask share one entry) ----------------
  assign usr_wdata_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push            = usr_wdata_valid & usr_wdata_ready;
  assign pop             = wdata_valid & wdata_ready;
  assign burst_buffered  = (count_q >= CNT_W'(BURST_LEN));
  assign {wdata_dqm, wdata} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {usr_wdqm, usr_wdata};
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ---------------- request FSM ----------------
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    beat_d      = beat_q;
    req_ready   = 1'b0;
    cmd_valid   = 1'b0;
    wdata_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = req_write | (rd_q < RD_W'(MAX_RD_OUTSTANDING));
        if (req_valid && req_ready) begin
          cmd_d = '{addr: req_addr & ADDR_MASK, rw: req_write,
                    auto_precharge_en: req_auto_pre};
          // A write whose burst is already buffered skips the wait state.
          if (req_write && !burst_buffered) state_d = WAIT_WD;
          else                              state_d = ISSUE;
        end
      end
      WAIT_WD: begin
        if (burst_buffered) state_d = ISSUE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          if (cmd_q.rw) begin
            state_d = STREAM;
            beat_d  = BEAT_W'(BURST_LEN);
          end else begin
            state_d = IDLE;
          end
        end
      end
      STREAM: begin
        wdata_valid = (count_q != '0);
        if (wdata_valid && wdata_ready) begin
          beat_d = beat_q - BEAT_W'(1);
          if (beat_q == BEAT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      beat_q  <= beat_d;
    end
  end

  assign cmd_data = cmd_q;

  // ---------------- read bursts in flight ----------------
  assign rd_inc = (state_q == ISSUE) & cmd_ready & ~cmd_q.rw;
  assign rd_dec = resp_done & (rd_q != '0);

  always_comb begin
    rd_d = rd_q;
    if (rd_inc && !rd_dec)      rd_d = rd_q + RD_W'(1);
    else if (rd_dec && !rd_inc) rd_d = rd_q - RD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_outstanding = rd_q;

endmodule

// File: tb/tb_sdram_req_frontend.sv
// Scoreboard bench for sdram_req_frontend: stimulus queues expected commands and
// write beats, a negedge monitor pops and compares on every controller-side handshake.
module tb_sdram_req_frontend;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_auto_pre;
  logic [23:0] req_addr;
  logic        usr_wdata_valid, usr_wdata_ready;
  logic [15:0] usr_wdata;
  logic [1:0]  usr_wdqm;
  logic        cmd_valid, cmd_ready;
  sdram_cmd_t  cmd_data;
  logic        wdata_valid, wdata_ready;
  logic [15:0] wdata;
  logic [1:0]  wdata_dqm;
  logic        resp_done;
  logic [1:0]  rd_outstanding;

  always #5 clk = ~clk;

  sdram_req_frontend dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_auto_pre(req_auto_pre),
    .usr_wdata_valid(usr_wdata_valid), .usr_wdata_ready(usr_wdata_ready),
    .usr_wdata(usr_wdata), .usr_wdqm(usr_wdqm),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata), .wdata_dqm(wdata_dqm),
    .resp_done(resp_done), .rd_outstanding(rd_outstanding)
  );

  int checks  = 0;
  int errors  = 0;
  int wd_pops = 0;
  sdram_cmd_t  exp_cmd_q[$];
  logic [17:0] exp_wd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // Monitor: one line per controller-side transaction.
  always @(negedge clk) begin
    sdram_cmd_t  e;
    logic [17:0] w;
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected: actual=0x%0h required=no command", cmd_data);
        end else begin
          e = exp_cmd_q.pop_front();
          chk("cmd_data", 32'(cmd_data), 32'(e));
          $display("cmd  addr=%06h rw=%0d ap=%0d", cmd_data.addr, cmd_data.rw,
                   cmd_data.auto_precharge_en);
        end
      end
      if (wdata_valid && wdata_ready) begin
        wd_pops++;
        if (exp_wd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wdata_unexpected: actual=0x%0h required=no beat", wdata);
        end else begin
          w = exp_wd_q.pop_front();
          chk("wdata_beat", 32'({wdata_dqm, wdata}), 32'(w));
          $display("beat data=%04h dqm=%0d", wdata, wdata_dqm);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, queue the hand-computed command.
  task automatic send_req(input logic wr, input logic [23:0] addr, input logic ap,
                          input logic [23:0] exp_addr);
    int n;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_auto_pre = ap;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) timeout_fail("req_accept");
    exp_cmd_q.push_back('{addr: exp_addr, rw: wr, auto_precharge_en: ap});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    int k;
    usr_wdata_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      usr_wdata = base + 16'(i);
      usr_wdqm  = 2'(i);
      k = 0;
      while (!usr_wdata_ready && k < 50) begin
        tick();
        k++;
      end
      if (!usr_wdata_ready) timeout_fail("push_ready");
      exp_wd_q.push_back({usr_wdqm, usr_wdata});
      tick();
    end
    usr_wdata_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target, input logic toggle);
    int n;
    n = 0;
    while (wd_pops < target && n < 100) begin
      if (toggle) wdata_ready = ~wdata_ready;
      tick();
      n++;
    end
    if (wd_pops < target) timeout_fail("stream_pops");
  endtask

  task automatic pulse_done();
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_auto_pre = 1'b0;
    usr_wdata_valid = 1'b0; usr_wdata = '0; usr_wdqm = '0;
    cmd_ready = 1'b1; wdata_ready = 1'b1; resp_done = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_wdata_valid", 32'(wdata_valid), 32'd0);
    chk("rst_rd_out", 32'(rd_outstanding), 32'd0);
    chk("rst_cmd_data", 32'(cmd_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wd_ready", 32'(usr_wdata_ready), 32'd1);
    rst = 1'b0;
    tick();

    // 1: write request first, then 8 words one per cycle; gapless stream
    send_req(1'b1, 24'h000100, 1'b0, 24'h000100);
    usr_wdata_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      usr_wdata = 16'h1000 + 16'(i);
      usr_wdqm  = 2'(i);
      exp_wd_q.push_back({usr_wdqm, usr_wdata});
      chk("t1_cmd_early", 32'(cmd_valid), 32'd0);
      tick();
    end
    usr_wdata_valid = 1'b0;
    // Count register holds 8 in this cycle; the FSM moves to ISSUE at the next edge.
    n = 0;
    while (!cmd_valid && n < 5) begin
      tick();
      n++;
    end
    chk("t1_cmd_latency", 32'(n), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t1_gapless", 32'(wdata_valid), 32'd1);
      tick();
    end
    chk("t1_no_extra", 32'(wdata_valid), 32'd0);
    chk("t1_pops", 32'(wd_pops), 32'd8);

    // 2: three reads, bounded by two in flight
    send_req(1'b0, 24'h200000, 1'b0, 24'h200000);
    tick();
    chk("t2_rd1", 32'(rd_outstanding), 32'd1);
    send_req(1'b0, 24'h40000b, 1'b0, 24'h400008);
    tick();
    chk("t2_rd2", 32'(rd_outstanding), 32'd2);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h600010; req_auto_pre = 1'b0;
    tick(); tick();
    chk("t2_blocked", 32'(req_ready), 32'd0);
    chk("t2_rd_hold", 32'(rd_outstanding), 32'd2);
    pulse_done();
    chk("t2_rd_after_done", 32'(rd_outstanding), 32'd1);
    chk("t2_unblocked", 32'(req_ready), 32'd1);
    exp_cmd_q.push_back('{addr: 24'h600010, rw: 1'b0, auto_precharge_en: 1'b0});
    tick();
    req_valid = 1'b0;
    tick();
    chk("t2_rd3", 32'(rd_outstanding), 32'd2);
    pulse_done();
    pulse_done();
    chk("t2_drained", 32'(rd_outstanding), 32'd0);
    pulse_done();
    chk("t2_no_underflow", 32'(rd_outstanding), 32'd0);

    // 4: unaligned read with auto-precharge, command held while controller stalls
    cmd_ready = 1'b0;
    send_req(1'b0, 24'h000105, 1'b1, 24'h000100);
    tick(); tick();
    chk("t4_hold_valid", 32'(cmd_valid), 32'd1);
    chk("t4_cmd_data", 32'(cmd_data), 32'h0000_0401);
    cmd_ready = 1'b1;
    tick();
    chk("t4_rd", 32'(rd_outstanding), 32'd1);
    pulse_done();
    chk("t4_rd_done", 32'(rd_outstanding), 32'd0);

    // 3: fill FIFO with no request, then a write issues right after acceptance
    push_words(16'h3000, 16);
    chk("t3_full", 32'(usr_wdata_ready), 32'd0);
    base = wd_pops;
    send_req(1'b1, 24'h00a000, 1'b0, 24'h00a000);
    chk("t3_cmd_latency", 32'(cmd_valid), 32'd1);
    wait_pops(base + 8, 1'b0);
    chk("t3_stream_end", 32'(wdata_valid), 32'd0);
    chk("t3_not_full", 32'(usr_wdata_ready), 32'd1);
    push_words(16'h3100, 8);
    chk("t3_count_was_8", 32'(usr_wdata_ready), 32'd0);

    // 5: wdata_ready toggling during STREAM
    base = wd_pops;
    wdata_ready = 1'b0;
    send_req(1'b1, 24'h00b000, 1'b0, 24'h00b000);
    wait_pops(base + 8, 1'b1);
    chk("t5_no_extra", 32'(wdata_valid), 32'd0);
    chk("t5_idle", 32'(req_ready), 32'd1);
    wdata_ready = 1'b1;

    // 6: reset in the middle of a write stream with a read outstanding
    send_req(1'b0, 24'hc00000, 1'b0, 24'hc00000);
    tick();
    chk("t6_rd", 32'(rd_outstanding), 32'd1);
    base = wd_pops;
    send_req(1'b1, 24'h00c000, 1'b0, 24'h00c000);
    wait_pops(base + 3, 1'b0);
    rst = 1'b1;
    wdata_ready = 1'b0;
    tick();
    chk("t6_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("t6_wdata_valid", 32'(wdata_valid), 32'd0);
    chk("t6_rd_out", 32'(rd_outstanding), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    chk("t6_cmd_data", 32'(cmd_data), 32'd0);
    chk("t6_wd_ready", 32'(usr_wdata_ready), 32'd1);
    rst = 1'b0;
    wdata_ready = 1'b1;
    exp_wd_q.delete();
    exp_cmd_q.delete();
    tick();
    // FIFO emptied by reset: a new write must wait for fresh words.
    base = wd_pops;
    send_req(1'b1, 24'h00d000, 1'b0, 24'h00d000);
    tick();
    chk("t6_fifo_empty", 32'(cmd_valid), 32'd0);
    push_words(16'h6000, 8);
    wait_pops(base + 8, 1'b0);
    tick();

    chk("end_cmd_queue", 32'(exp_cmd_q.size()), 32'd0);
    chk("end_wd_queue", 32'(exp_wd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
